// File: rtl/operand_hazard_ctrl.sv
// Operand-decode hazard control: EX/WB write tracking, forwarding selects,
// load-use detection and a memory-operand req/ack sequencer with timeout.
module operand_hazard_ctrl #(
  parameter int REG_AW      = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_e_r0,
  input  logic              id_e_rn,
  input  logic [REG_AW-1:0] id_rn,
  input  logic              id_l_r0,
  input  logic              id_l_rn,
  input  logic [REG_AW-1:0] id_wn,
  input  logic              id_is_load,
  input  logic              id_s_od,
  input  logic              flush,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              od_stall,
  output logic              ex_bubble,
  output logic [1:0]        fwd_r0_sel,
  output logic [1:0]        fwd_rn_sel,
  output logic              mem_err
);

  typedef struct packed {
    logic              valid;
    logic              wr_r0;
    logic              wr_rn;
    logic [REG_AW-1:0] wn;
    logic              is_load;
  } tag_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_EX = 2'b01;
  localparam logic [1:0] SEL_WB = 2'b10;
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam tag_t       TAG_NONE = '0;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       mem_req_reg, mem_err_reg;
  tag_t       ex_tag_reg, ex_tag_next;
  tag_t       wb_tag_reg, wb_tag_next;

  logic       load_use;
  logic       sod_start;
  logic       stall_raw;

  // An RN write to index 0 lands in R0, so it counts as an R0 write.
  function automatic logic tag_writes_r0(input tag_t t);
    return t.valid & (t.wr_r0 | (t.wr_rn & (t.wn == '0)));
  endfunction

  function automatic logic tag_writes_rn(input tag_t t, input logic [REG_AW-1:0] idx);
    return t.valid & t.wr_rn & (t.wn == idx);
  endfunction

  // Operand 0 is the R0 mux, operand 1 the RN mux. An RN read of index 0
  // reads R0, so it is matched against R0 writers.
  logic [1:0] op_rd_r0;
  logic [1:0] op_rd_rn;
  logic [1:0] ex_hit;
  logic [1:0] wb_hit;
  logic [1:0] fwd_sel [2];

  assign op_rd_r0[0] = id_valid & id_e_r0;
  assign op_rd_rn[0] = 1'b0;
  assign op_rd_r0[1] = id_valid & id_e_rn & (id_rn == '0);
  assign op_rd_rn[1] = id_valid & id_e_rn & (id_rn != '0);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      assign ex_hit[gi] = (op_rd_r0[gi] & tag_writes_r0(ex_tag_reg))
                        | (op_rd_rn[gi] & tag_writes_rn(ex_tag_reg, id_rn));
      assign wb_hit[gi] = (op_rd_r0[gi] & tag_writes_r0(wb_tag_reg))
                        | (op_rd_rn[gi] & tag_writes_rn(wb_tag_reg, id_rn));
      assign fwd_sel[gi] = ex_hit[gi] ? SEL_EX :
                           wb_hit[gi] ? SEL_WB : SEL_RF;
    end
  endgenerate

  assign load_use  = (|ex_hit) & ex_tag_reg.is_load;
  assign sod_start = (state_reg == S_IDLE) & id_valid & id_s_od & ~flush;

  // State register, counter, registered memory outputs and pipeline tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      mem_req_reg <= 1'b0;
      mem_err_reg <= 1'b0;
      ex_tag_reg  <= TAG_NONE;
      wb_tag_reg  <= TAG_NONE;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      mem_req_reg <= (state_next == S_WAIT);
      mem_err_reg <= (state_next == S_ERR);
      ex_tag_reg  <= ex_tag_next;
      wb_tag_reg  <= wb_tag_next;
    end
  end

  // Next-state logic; a load-use stall defers the memory request.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    case (state_reg)
      S_IDLE: begin
        if (sod_start && !load_use) state_next = S_WAIT;
      end
      S_WAIT: begin
        cnt_next = cnt_reg + 8'd1;
        if (flush || mem_ack)             state_next = S_IDLE;
        else if (cnt_reg == TIMEOUT_LAST) state_next = S_ERR;
      end
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // Output logic and tag advance.
  always_comb begin
    stall_raw = load_use | sod_start
              | ((state_reg == S_WAIT) & ~mem_ack)
              | (state_reg == S_ERR);
    od_stall   = rst_n & stall_raw;
    ex_bubble  = rst_n & (stall_raw | flush);
    fwd_r0_sel = fwd_sel[0];
    fwd_rn_sel = fwd_sel[1];
    mem_req    = mem_req_reg;
    mem_err    = mem_err_reg;

    wb_tag_next = flush ? TAG_NONE : ex_tag_reg;
    ex_tag_next = TAG_NONE;
    if (!(stall_raw || flush) && id_valid) begin
      ex_tag_next.valid   = 1'b1;
      ex_tag_next.wr_r0   = id_l_r0;
      ex_tag_next.wr_rn   = id_l_rn;
      ex_tag_next.wn      = id_wn;
      ex_tag_next.is_load = id_is_load;
    end
  end

endmodule
